// File: rtl/axil_pkg.sv
// Shared AXI4-Lite widths, response codes and FSM state encodings for the
// default/error slave.
package axil_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_W,
    W_WAIT_AW,
    W_RESP
  } w_state_e;

endpackage

// File: rtl/axil_sat_counter.sv
// Up-counter with synchronous clear that sticks at all ones instead of
// wrapping.
module axil_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/axil_default_slave.sv
// AXI4-Lite default slave: completes every access with RESP_CODE.
// Define AXIL_DEFAULT_SLAVE_ERR_LOG_EN to build the error counters/address log.
//
// state     | meaning
// R_IDLE    | arready high, waiting for a read address
// R_RESP    | R beat presented, held until rready
// W_IDLE    | awready and wready high
// W_WAIT_W  | address taken, waiting for write data
// W_WAIT_AW | data taken, waiting for write address
// W_RESP    | B beat presented, held until bready
module axil_default_slave
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
  parameter logic [1:0]            RESP_CODE  = RESP_DECERR,
  parameter logic [DATA_WIDTH-1:0] RDATA_FILL = '1,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [CNT_WIDTH-1:0]    err_wr_cnt,
  output logic [CNT_WIDTH-1:0]    err_rd_cnt,
  output logic [ADDR_WIDTH-1:0]   err_last_addr,
  output logic                    err_last_is_wr
);

  r_state_e              r_state_d, r_state_q;
  logic                  arready_d, arready_q;
  logic                  rvalid_d, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic [1:0]            rresp_d, rresp_q;
  logic                  ar_hs;

  assign ar_hs = s_axil_arvalid & arready_q;

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      R_RESP:  if (s_axil_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    // Outputs are decoded from the next state so they are registered
    // alongside it and change on the same edge.
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_RESP);
    rdata_d   = rvalid_d ? RDATA_FILL : '0;
    rresp_d   = rvalid_d ? RESP_CODE : RESP_OKAY;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  w_state_e   w_state_d, w_state_q;
  logic       awready_d, awready_q;
  logic       wready_d, wready_q;
  logic       bvalid_d, bvalid_q;
  logic [1:0] bresp_d, bresp_q;
  logic       aw_hs, w_hs;

  assign aw_hs = s_axil_awvalid & awready_q;
  assign w_hs  = s_axil_wvalid & wready_q;

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_d = W_RESP;
        else if (aw_hs)    w_state_d = W_WAIT_W;
        else if (w_hs)     w_state_d = W_WAIT_AW;
      end
      W_WAIT_W:  if (w_hs) w_state_d = W_RESP;
      W_WAIT_AW: if (aw_hs) w_state_d = W_RESP;
      W_RESP:    if (s_axil_bready) w_state_d = W_IDLE;
      default:   w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_AW);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_W);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = bvalid_d ? RESP_CODE : RESP_OKAY;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

`ifdef AXIL_DEFAULT_SLAVE_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] last_addr_d, last_addr_q;
  logic                  last_is_wr_d, last_is_wr_q;
  logic                  unused_wr_payload;

  assign unused_wr_payload = ^{s_axil_wdata, s_axil_wstrb};

  axil_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk (aclk),
    .clr (areset),
    .inc (aw_hs),
    .cnt (err_wr_cnt)
  );

  axil_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk (aclk),
    .clr (areset),
    .inc (ar_hs),
    .cnt (err_rd_cnt)
  );

  // Read is checked first so it wins a same-cycle capture.
  always_comb begin
    last_addr_d  = last_addr_q;
    last_is_wr_d = last_is_wr_q;
    if (ar_hs) begin
      last_addr_d  = s_axil_araddr;
      last_is_wr_d = 1'b0;
    end else if (aw_hs) begin
      last_addr_d  = s_axil_awaddr;
      last_is_wr_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      last_addr_q  <= '0;
      last_is_wr_q <= 1'b0;
    end else begin
      last_addr_q  <= last_addr_d;
      last_is_wr_q <= last_is_wr_d;
    end
  end

  assign err_last_addr  = last_addr_q;
  assign err_last_is_wr = last_is_wr_q;
`else
  logic unused_inputs;

  assign unused_inputs  = ^{s_axil_wdata, s_axil_wstrb, s_axil_awaddr, s_axil_araddr};
  assign err_wr_cnt     = '0;
  assign err_rd_cnt     = '0;
  assign err_last_addr  = '0;
  assign err_last_is_wr = 1'b0;
`endif

endmodule

// File: tb/tb_axil_default_slave.sv
// Scoreboard bench for axil_default_slave: drivers push expected R/B beats,
// a negedge monitor pops and checks them along with latency and stability.
module tb_axil_default_slave;
  import axil_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int CW  = 2;
  localparam int TMO = 50;
`ifdef AXIL_DEFAULT_SLAVE_ERR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic [AW-1:0]   awaddr = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b1;
  logic [AW-1:0]   araddr = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready = 1'b1;
  logic [CW-1:0]   err_wr_cnt, err_rd_cnt;
  logic [AW-1:0]   err_last_addr;
  logic            err_last_is_wr;

  always #5 aclk = ~aclk;

  axil_default_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .err_wr_cnt(err_wr_cnt), .err_rd_cnt(err_rd_cnt),
    .err_last_addr(err_last_addr), .err_last_is_wr(err_last_is_wr)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int r_seen = 0;
  int b_seen = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; logic [1:0] resp; int due; } r_exp_t;
  typedef struct { logic [1:0] resp; int due; } b_exp_t;
  r_exp_t r_q[$];
  b_exp_t b_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic          prev_rvalid = 1'b0, prev_rhs = 1'b0;
  logic          prev_bvalid = 1'b0, prev_bhs = 1'b0;
  logic [DW-1:0] hold_rdata;
  logic [1:0]    hold_rresp, hold_bresp;

  always @(negedge aclk) begin
    if (areset) begin
      prev_rvalid = 1'b0; prev_rhs = 1'b0;
      prev_bvalid = 1'b0; prev_bhs = 1'b0;
    end else begin
      if (rvalid) begin
        chk("arready_low_while_rvalid", arready, 0);
        if (!prev_rvalid || prev_rhs) begin
          chk("r_beat_expected", r_q.size() != 0, 1);
          if (r_q.size() != 0) chk("r_latency", cyc, r_q[0].due);
        end else begin
          chk("rdata_stable", rdata, hold_rdata);
          chk("rresp_stable", rresp, hold_rresp);
        end
        hold_rdata = rdata;
        hold_rresp = rresp;
        if (rready && r_q.size() != 0) begin
          r_exp_t e;
          e = r_q.pop_front();
          chk("rdata", rdata, e.data);
          chk("rresp", rresp, e.resp);
          r_seen++;
        end
      end else begin
        chk("rdata_idle_zero", {rresp, rdata}, 0);
        if (prev_rhs) chk("arready_after_r", arready, 1);
      end
      prev_rhs    = rvalid && rready;
      prev_rvalid = rvalid;

      if (bvalid) begin
        chk("aw_w_ready_low_while_bvalid", {awready, wready}, 0);
        if (!prev_bvalid || prev_bhs) begin
          chk("b_beat_expected", b_q.size() != 0, 1);
          if (b_q.size() != 0) chk("b_latency", cyc, b_q[0].due);
        end else begin
          chk("bresp_stable", bresp, hold_bresp);
        end
        hold_bresp = bresp;
        if (bready && b_q.size() != 0) begin
          b_exp_t e;
          e = b_q.pop_front();
          chk("bresp", bresp, e.resp);
          b_seen++;
        end
      end else begin
        chk("bresp_idle_zero", bresp, 0);
        if (prev_bhs) chk("aw_w_ready_after_b", {awready, wready}, 2'b11);
      end
      prev_bhs    = bvalid && bready;
      prev_bvalid = bvalid;
    end
  end

  task automatic do_read(input logic [AW-1:0] a);
    int t = 0;
    @(posedge aclk); #1;
    arvalid = 1'b1; araddr = a;
    forever begin
      @(negedge aclk);
      if (arready) begin
        r_q.push_back('{32'hFFFF_FFFF, 2'b11, cyc + 1});
        break;
      end
      t++;
      if (t > TMO) begin chk("ar_hs_timeout", t, TMO); break; end
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int aw_dly, input int w_dly);
    int aw_c = 0;
    int w_c  = 0;
    @(posedge aclk); #1;
    fork
      begin
        int t = 0;
        for (int i = 0; i < aw_dly; i++) begin @(posedge aclk); #1; end
        awvalid = 1'b1; awaddr = a;
        forever begin
          @(negedge aclk);
          if (awready) begin aw_c = cyc; break; end
          t++;
          if (t > TMO) begin chk("aw_hs_timeout", t, TMO); aw_c = cyc; break; end
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
      end
      begin
        int t = 0;
        for (int i = 0; i < w_dly; i++) begin @(posedge aclk); #1; end
        wvalid = 1'b1; wdata = a ^ 32'h5A5A_5A5A; wstrb = 4'hF;
        forever begin
          @(negedge aclk);
          if (wready) begin w_c = cyc; break; end
          t++;
          if (t > TMO) begin chk("w_hs_timeout", t, TMO); w_c = cyc; break; end
        end
        @(posedge aclk); #1;
        wvalid = 1'b0;
      end
    join
    b_q.push_back('{2'b11, ((aw_c > w_c) ? aw_c : w_c) + 1});
  endtask

  task automatic drain();
    int t = 0;
    while ((r_q.size() + b_q.size()) != 0 && t < 200) begin
      @(negedge aclk);
      t++;
    end
    chk("drain_pending", r_q.size() + b_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    @(negedge aclk);
    chk({tag, "_ctrl"}, {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_log"}, {err_wr_cnt, err_rd_cnt, err_last_addr, err_last_is_wr}, 0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk);
    chk_all_zero(tag);
    r_q.delete();
    b_q.delete();
    @(posedge aclk); #1;
    areset = 1'b0;
    rready = 1'b1;
    bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk({tag, "_ready_after_release"}, {arready, awready, wready}, 3'b111);
  endtask

  initial begin
    int rs, bs, t;
    logic [AW-1:0] a;

    repeat (3) @(posedge aclk);
    chk_all_zero("reset");
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("ready_after_reset", {arready, awready, wready}, 3'b111);

    // Single read
    do_read(32'h0000_1000);
    drain();

    // Write orderings: same cycle, AW 3 before W, W 2 before AW
    bs = b_seen;
    do_write(32'h0000_3000, 0, 0);
    do_write(32'h0000_3004, 0, 3);
    do_write(32'h0000_3008, 2, 0);
    drain();
    chk("write_order_b_count", b_seen - bs, 3);

    // Backpressure on both response channels
    rready = 1'b0;
    bready = 1'b0;
    fork
      do_read(32'h0000_4000);
      do_write(32'h0000_4004, 0, 0);
    join
    repeat (5) @(negedge aclk);
    chk("bp_valids_held", {rvalid, bvalid}, 2'b11);
    chk("bp_readies_low", {arready, awready, wready}, 0);
    @(posedge aclk); #1;
    rready = 1'b1;
    bready = 1'b1;
    drain();

    // Concurrent reads and writes
    rs = r_seen;
    bs = b_seen;
    fork
      for (int i = 0; i < 4; i++) do_read(32'h0000_5000 + 32'(i * 4));
      begin
        do_write(32'h0000_6000, 0, 0);
        do_write(32'h0000_6004, 1, 0);
        do_write(32'h0000_6008, 0, 1);
        do_write(32'h0000_600C, 0, 0);
      end
    join
    drain();
    chk("concurrent_r_count", r_seen - rs, 4);
    chk("concurrent_b_count", b_seen - bs, 4);

    // Reset while in R_RESP
    rready = 1'b0;
    do_read(32'h0000_7000);
    t = 0;
    while (!rvalid && t < TMO) begin @(negedge aclk); t++; end
    chk("r_resp_reached", rvalid, 1);
    pulse_reset("rst_r_resp");
    repeat (5) @(negedge aclk);
    chk("no_stale_r", rvalid, 0);

    // Reset while in W_WAIT_W
    @(posedge aclk); #1;
    awvalid = 1'b1; awaddr = 32'h0000_7100;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    chk("wait_w_readies", {awready, wready}, 2'b01);
    pulse_reset("rst_wait_w");
    repeat (5) @(negedge aclk);
    chk("no_stale_b", bvalid, 0);
    do_write(32'h0000_7104, 0, 0);
    drain();

    // Logging: counters saturate at CW bits, last address from final read
    pulse_reset("rst_log");
    a = 32'h0000_2014;
    for (int i = 0; i < 5; i++) begin
      do_read(a);
      a = a - 32'h4;
    end
    drain();
    @(negedge aclk);
    chk("log_rd_cnt", err_rd_cnt, LOG_EN ? 2'd3 : 2'd0);
    chk("log_wr_cnt", err_wr_cnt, 0);
    chk("log_last_addr", err_last_addr, LOG_EN ? 32'h0000_2004 : 32'h0);
    chk("log_last_is_wr", err_last_is_wr, 0);
    do_write(32'h0000_2100, 0, 0);
    drain();
    chk("log_wr_cnt_after_write", err_wr_cnt, LOG_EN ? 2'd1 : 2'd0);
    chk("log_last_after_write", {err_last_is_wr, err_last_addr}, LOG_EN ? {1'b1, 32'h0000_2100} : 33'h0);

    repeat (3) @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
